aes_core: RTL

AES_CORE -- requirements
Module: aes_core

---
 rtl/aes_if.sv | 19 +
 rtl/aes_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/aes_if.sv
// Handshake bundle for aes_core: key load, block in, result out.
interface aes_if #(parameter int KEY_BITS = 128);
  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key;
  logic                key_loaded;
  logic                in_valid;
  logic                in_ready;
  logic                in_decrypt;
  logic [127:0]        in_data;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_data;

  modport master (output key_valid, key, in_valid, in_decrypt, in_data, out_ready,
                  input  key_ready, key_loaded, in_ready, out_valid, out_data);
  modport slave  (input  key_valid, key, in_valid, in_decrypt, in_data, out_ready,
                  output key_ready, key_loaded, in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_core.sv
// Iterative AES-128/192/256 encrypt/decrypt core: one word of key schedule per
// cycle during expansion, then one full round per cycle per block.
module aes_core #(
  parameter int KEY_BITS = 128
) (
  input logic  clk,
  input logic  rst_n,
  aes_if.slave bus
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int W  = 4 * (NR + 1);

  localparam logic [1:0] IDLE = 2'd0, KEXP = 2'd1, RUN = 2'd2, DONE = 2'd3;

  logic [1:0]   state;
  logic [31:0]  w [W];
  logic [5:0]   kidx;
  logic [2:0]   kmod;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic         dec, loaded;
  logic [127:0] st, out_q;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); 0 maps to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x; r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [31:0] imixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] byt(input logic [127:0] s, input int k);
    return s[127-8*k -: 8];
  endfunction

  // Round key select: the accept cycle whitens with rk[0] or rk[Nr]
  logic [3:0]   rk_sel;
  logic [127:0] rk;
  always_comb begin
    if (state == IDLE) rk_sel = bus.in_decrypt ? 4'(NR) : 4'd0;
    else               rk_sel = dec ? 4'(NR) - rnd : rnd;
    rk = {w[{rk_sel, 2'b00}], w[{rk_sel, 2'b01}], w[{rk_sel, 2'b10}], w[{rk_sel, 2'b11}]};
  end

  logic [127:0] sr_sb, isr_isb, enc_mc, dec_ark, dec_imc, enc_nxt, dec_nxt;
  always_comb begin
    sr_sb = '0; isr_isb = '0; enc_mc = '0; dec_imc = '0;
    for (int k = 0; k < 16; k++) begin
      sr_sb[127-8*k -: 8]   = sbox(byt(st, 4*(((k>>2) + (k&3)) & 3) + (k&3)));
      isr_isb[127-8*k -: 8] = isbox(byt(st, 4*(((k>>2) - (k&3)) & 3) + (k&3)));
    end
    dec_ark = isr_isb ^ rk;
    for (int c = 0; c < 4; c++) begin
      enc_mc[127-32*c -: 32]  = mixcol(sr_sb[127-32*c -: 32]);
      dec_imc[127-32*c -: 32] = imixcol(dec_ark[127-32*c -: 32]);
    end
    enc_nxt = ((rnd == 4'(NR)) ? sr_sb : enc_mc) ^ rk;
    dec_nxt = (rnd == 4'(NR)) ? dec_ark : dec_imc;
  end

  // Next schedule word; kmod tracks i mod Nk without a divider
  logic [31:0] kprev, ktmp, knew;
  always_comb begin
    kprev = w[kidx - 6'd1];
    ktmp  = kprev;
    if (kmod == 3'd0)                 ktmp = subword({kprev[23:0], kprev[31:24]}) ^ {rcon, 24'h0};
    else if (NK == 8 && kmod == 3'd4) ktmp = subword(kprev);
    knew = w[kidx - 6'(NK)] ^ ktmp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      loaded <= 1'b0;
      out_q  <= '0;
      rnd    <= '0;
      kidx   <= '0;
      kmod   <= '0;
      rcon   <= 8'h01;
      dec    <= 1'b0;
      st     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            loaded <= 1'b0;
            kidx   <= 6'(NK);
            kmod   <= '0;
            rcon   <= 8'h01;
            state  <= KEXP;
          end else if (bus.in_valid && loaded) begin
            st    <= bus.in_data ^ rk;
            dec   <= bus.in_decrypt;
            rnd   <= 4'd1;
            state <= RUN;
          end
        end
        KEXP: begin
          kidx <= kidx + 6'd1;
          kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xt(rcon);
          if (kidx == 6'(W - 1)) begin
            kidx   <= '0;
            loaded <= 1'b1;
            state  <= IDLE;
          end
        end
        RUN: begin
          st  <= dec ? dec_nxt : enc_nxt;
          rnd <= rnd + 4'd1;
          if (rnd == 4'(NR)) begin
            out_q <= dec ? dec_nxt : enc_nxt;
            rnd   <= '0;
            state <= DONE;
          end
        end
        default: if (bus.out_ready) state <= IDLE;
      endcase
    end
  end

  // Schedule storage needs no reset: loaded gates every use of it
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.key_valid) begin
      for (int i = 0; i < NK; i++) w[i] <= bus.key[KEY_BITS-1-32*i -: 32];
    end else if (state == KEXP) begin
      w[kidx] <= knew;
    end
  end

  assign bus.key_ready  = (state == IDLE);
  assign bus.in_ready   = (state == IDLE) && loaded && !bus.key_valid;
  assign bus.key_loaded = loaded;
  assign bus.out_valid  = (state == DONE);
  assign bus.out_data   = out_q;
endmodule
